// File: rtl/systolic_feeder_4x4_if.sv
// Load port bundle for the 4x4 systolic feeder.
//   valid : load word valid (driven by the producer)
//   ready : feeder accepts the load word (driven by the feeder)
//   data  : packed word, element k = data[k*DW +: DW]
// The producer side uses the master modport, the feeder the slave modport.
interface systolic_feeder_4x4_if #(
    parameter int DW = 8
);
    logic            valid;
    logic            ready;
    logic [4*DW-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/systolic_feeder_4x4.sv
// Operand transmitter for a 4x4 output-stationary systolic array.
// Buffers four A rows and four B columns from the load port, then on start
// pulses the array clear and feeds skewed row/column operand streams,
// followed by zero-operand drain cycles and a one-cycle done pulse.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   ld           : load port (valid/ready/data), slave side
//   start        : begin multiply, only honoured once all 8 words are loaded
//   arr_clr      : one-cycle active-high clear for the array accumulators
//   a1..a4       : signed row operands, array west edge
//   b1..b4       : signed column operands, array north edge
//   busy         : high while clearing, feeding or draining
//   done         : one-cycle pulse once the array results are final
module systolic_feeder_4x4 #(
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 3   // must be at least 1
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_feeder_4x4_if.slave ld,
    input  logic                 start,
    output logic                 arr_clr,
    output logic signed [DW-1:0] a1,
    output logic signed [DW-1:0] a2,
    output logic signed [DW-1:0] a3,
    output logic signed [DW-1:0] a4,
    output logic signed [DW-1:0] b1,
    output logic signed [DW-1:0] b2,
    output logic signed [DW-1:0] b3,
    output logic signed [DW-1:0] b4,
    output logic                 busy,
    output logic                 done
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FULL,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [2:0]         wcnt;
    logic [2:0]         t;
    logic [DCW-1:0]     dcnt;
    logic               ready_q;

    // a_buf[r][k] = A[r][k]; b_buf[c][k] = B[k][c] (columns stored as loaded)
    logic [DW-1:0]      a_buf [4][4];
    logic [DW-1:0]      b_buf [4][4];

    logic signed [DW-1:0] a_q   [4];
    logic signed [DW-1:0] b_q   [4];
    logic signed [DW-1:0] a_nxt [4];
    logic signed [DW-1:0] b_nxt [4];
    logic [2:0]           t_nxt;
    logic                 xfer;

    assign ld.ready = ready_q;
    assign xfer     = ld.valid & ready_q;

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];
    assign b4 = b_q[3];

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (!wcnt[2])
                    a_buf[wcnt[1:0]][k] <= ld.data[k*DW +: DW];
                else
                    b_buf[wcnt[1:0]][k] <= ld.data[k*DW +: DW];
            end
        end
    end

    // Operands are registered one cycle ahead: this computes the values for
    // the feed step about to be presented (t=0 when leaving CLEAR).
    always_comb begin
        int unsigned tn;
        t_nxt = (state == S_CLEAR) ? 3'd0 : t + 3'd1;
        tn    = 32'(t_nxt);
        for (int unsigned i = 0; i < 4; i++) begin
            a_nxt[i] = '0;
            b_nxt[i] = '0;
            if (tn >= i && tn <= i + 3) begin
                a_nxt[i] = a_buf[i][2'(tn - i)];
                b_nxt[i] = b_buf[i][2'(tn - i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            t       <= '0;
            dcnt    <= '0;
            ready_q <= 1'b1;
            arr_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        wcnt <= wcnt + 3'd1;
                        if (wcnt == 3'd7) begin
                            state   <= S_FULL;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        state   <= S_CLEAR;
                        arr_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state   <= S_FEED;
                    arr_clr <= 1'b0;
                    t       <= t_nxt;
                    a_q     <= a_nxt;
                    b_q     <= b_nxt;
                end
                S_FEED: begin
                    if (t == 3'd6) begin
                        state <= S_DRAIN;
                        dcnt  <= '0;
                        a_q   <= '{default: '0};
                        b_q   <= '{default: '0};
                    end else begin
                        t   <= t_nxt;
                        a_q <= a_nxt;
                        b_q <= b_nxt;
                    end
                end
                S_DRAIN: begin
                    if (dcnt == DCW'(DRAIN_CYCLES - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done    <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Self-checking bench for systolic_feeder_4x4: loads matrices, runs the
// multiply, checks every operand cycle against the skew rule, and rebuilds
// each array result from the observed streams against a direct A*B.
module tb_systolic_feeder_4x4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic arr_clr, busy, done;
    logic signed [DW-1:0] a1, a2, a3, a4, b1, b2, b3, b4;
    logic signed [DW-1:0] av [4];
    logic signed [DW-1:0] bv [4];

    int checks = 0;
    int errors = 0;
    int A [4][4];
    int B [4][4];

    systolic_feeder_4x4_if #(.DW(DW)) ld ();

    systolic_feeder_4x4 #(.DW(DW), .DRAIN_CYCLES(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld.slave),
        .start   (start),
        .arr_clr (arr_clr),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .a4      (a4),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3),
        .b4      (b4),
        .busy    (busy),
        .done    (done)
    );

    assign av[0] = a1;
    assign av[1] = a2;
    assign av[2] = a3;
    assign av[3] = a4;
    assign bv[0] = b1;
    assign bv[1] = b2;
    assign bv[2] = b3;
    assign bv[3] = b4;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0: begin A[i][j] = (i == j) ? 1 : 0; B[i][j] = 4*i + j + 1; end
                    1: begin A[i][j] = -128;             B[i][j] = -128;        end
                    2: begin A[i][j] = -1;               B[i][j] = 2;           end
                    3: begin A[i][j] = 10*i + j + 1;     B[i][j] = 10*i + j + 1; end
                    default: begin
                        A[i][j] = int'($urandom_range(255)) - 128;
                        B[i][j] = int'($urandom_range(255)) - 128;
                    end
                endcase
            end
        end
    endtask

    function automatic logic [4*DW-1:0] word(input int w);
        logic [4*DW-1:0] d;
        for (int k = 0; k < 4; k++)
            d[k*DW +: DW] = (w < 4) ? DW'(A[w][k]) : DW'(B[k][w-4]);
        return d;
    endfunction

    // Expected operand for edge lane i at feed step t.
    function automatic int exp_op(input bit is_b, input int i, input int t);
        if (t - i < 0 || t - i > 3) return 0;
        return is_b ? B[t-i][i] : A[i][t-i];
    endfunction

    // Loads 8 words; with toggle, valid drops every other cycle and a start
    // pulse is issued after the fifth word.
    task automatic load(input bit toggle);
        for (int w = 0; w < 8; w++) begin
            ld.valid = 1'b1;
            ld.data  = word(w);
            check($sformatf("ld_ready_w%0d", w), ld.ready, 1);
            tick();
            if (toggle && w < 7) begin
                ld.valid = 1'b0;
                ld.data  = $urandom;
                if (w == 4) start = 1'b1;
                tick();
                start = 1'b0;
                check($sformatf("gap_ready_w%0d", w), ld.ready, 1);
                check($sformatf("gap_busy_w%0d", w), busy, 0);
                check($sformatf("gap_clr_w%0d", w), arr_clr, 0);
            end
        end
        ld.valid = 1'b1;
        ld.data  = $urandom;
        check("full_ready", ld.ready, 0);
        tick();
        ld.valid = 1'b0;
        check("full_ready_hold", ld.ready, 0);
        check("full_busy", busy, 0);
    endtask

    task automatic run(input int abort_t);
        int as [4][7];
        int bs [4][7];
        start = 1'b1;
        tick();
        start    = 1'b0;
        ld.valid = 1'b1;
        ld.data  = $urandom;
        check("clr_pulse", arr_clr, 1);
        check("clr_busy", busy, 1);
        check("clr_ready", ld.ready, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clr_a%0d", i+1), av[i], 0);
            check($sformatf("clr_b%0d", i+1), bv[i], 0);
        end
        for (int t = 0; t < 7; t++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("feed_t%0d_a%0d", t, i+1), av[i], exp_op(0, i, t));
                check($sformatf("feed_t%0d_b%0d", t, i+1), bv[i], exp_op(1, i, t));
                as[i][t] = av[i];
                bs[i][t] = bv[i];
            end
            check($sformatf("feed_t%0d_clr", t), arr_clr, 0);
            check($sformatf("feed_t%0d_busy", t), busy, 1);
            check($sformatf("feed_t%0d_ready", t), ld.ready, 0);
            if (t == abort_t) begin
                ld.valid = 1'b0;
                rst = 1'b0;
                #1;
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("rst_a%0d", i+1), av[i], 0);
                    check($sformatf("rst_b%0d", i+1), bv[i], 0);
                end
                check("rst_busy", busy, 0);
                check("rst_clr", arr_clr, 0);
                check("rst_done", done, 0);
                #2;
                rst = 1'b1;
                for (int c = 0; c < 14; c++) begin
                    tick();
                    check($sformatf("post_rst_done_c%0d", c), done, 0);
                    check($sformatf("post_rst_ready_c%0d", c), ld.ready, 1);
                end
                return;
            end
        end
        for (int d = 0; d < 3; d++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("drain%0d_a%0d", d, i+1), av[i], 0);
                check($sformatf("drain%0d_b%0d", d, i+1), bv[i], 0);
            end
            check($sformatf("drain%0d_busy", d), busy, 1);
            check($sformatf("drain%0d_done", d), done, 0);
        end
        ld.valid = 1'b0;
        tick();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_ready", ld.ready, 0);
        tick();
        check("idle_done", done, 0);
        check("idle_ready", ld.ready, 1);
        // Array PE(i,j) sees row i delayed j cycles and column j delayed i.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int acc = 0;
                int ref_c = 0;
                for (int t = 0; t < 13; t++) begin
                    int ta = t - j;
                    int tc = t - i;
                    if (ta >= 0 && ta < 7 && tc >= 0 && tc < 7)
                        acc += as[i][ta] * bs[j][tc];
                end
                for (int k = 0; k < 4; k++) ref_c += A[i][k] * B[k][j];
                check($sformatf("c%0d%0d", i+1, j+1), acc, ref_c);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        ld.valid = 1'b0;
        ld.data  = '0;
        #12;
        check("reset_ready", ld.ready, 1);
        check("reset_clr", arr_clr, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_a%0d", i+1), av[i], 0);
            check($sformatf("reset_b%0d", i+1), bv[i], 0);
        end
        rst = 1'b1;
        tick();

        fill(0); load(0); run(-1);   // identity A: results equal B
        fill(1); load(0); run(-1);   // most negative operands
        fill(2); load(0); run(-1);   // sign extension
        fill(3); load(1); run(-1);   // skew pattern, toggled load with early start
        fill(4); load(0); run(3);    // reset during feed
        fill(4); load(0); run(-1);   // back-to-back random
        fill(4); load(1); run(-1);
        fill(4); load(0); run(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
